// File: rtl/ov7670_stream_gen.sv
// Synthetic OV7670 parallel-output source: PCLK/VSYNC/HREF plus an RGB565 byte stream, high byte first.
// Define OV7670_GEN_SWAP_RB_EN to exchange the R and B fields of every pixel before the byte split.
module ov7670_stream_gen #(
  parameter int unsigned c_img_cols    = 80,
  parameter int unsigned c_img_rows    = 60,
  parameter int unsigned c_hblank      = 16,
  parameter int unsigned c_vsync_lines = 3,
  parameter int unsigned c_vbp_lines   = 2,
  parameter int unsigned c_vfp_lines   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] pattern,
  output logic       pclk,
  output logic       vsync,
  output logic       href,
  output logic [7:0] d,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned c_act_bytes   = 2 * c_img_cols;
  localparam int unsigned c_line        = c_act_bytes + c_hblank;
  localparam int unsigned c_first_act   = c_vsync_lines + c_vbp_lines;
  localparam int unsigned c_first_vfp   = c_first_act + c_img_rows;
  localparam int unsigned c_total_lines = c_first_vfp + c_vfp_lines;
  localparam int unsigned c_bw          = $clog2(c_line);
  localparam int unsigned c_lw          = $clog2(c_total_lines + 1);
  localparam int unsigned c_cw          = $clog2(c_img_cols);
  localparam int unsigned c_rw          = $clog2(c_img_rows);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBP,
    S_ACTIVE,
    S_VFP
  } state_t;

  state_t            state;
  state_t            nxt_phase;
  logic [c_bw-1:0]   byte_cnt;
  logic [c_bw-1:0]   nxt_byte;
  logic [c_lw-1:0]   line_cnt;
  logic [c_lw-1:0]   nxt_line;
  logic [1:0]        pat;
  logic              line_end;
  logic              frame_end;
  logic              nxt_href;
  logic [7:0]        nxt_d;
  logic [c_cw-1:0]   col;
  logic [c_rw-1:0]   row;
  logic [15:0]       col16;
  logic [15:0]       row16;
  logic [12:0]       pix_idx;
  logic [15:0]       pix;
  logic [15:0]       pix_out;

  // Position of the byte tick that follows the one currently on the outputs.
  always_comb begin
    line_end  = (byte_cnt == c_bw'(c_line - 1));
    frame_end = line_end && (line_cnt == c_lw'(c_total_lines - 1));
    nxt_byte  = line_end ? '0 : byte_cnt + c_bw'(1);
    nxt_line  = line_end ? line_cnt + c_lw'(1) : line_cnt;
    if (nxt_line < c_lw'(c_vsync_lines)) begin
      nxt_phase = S_VSYNC;
    end else if (nxt_line < c_lw'(c_first_act)) begin
      nxt_phase = S_VBP;
    end else if (nxt_line < c_lw'(c_first_vfp)) begin
      nxt_phase = S_ACTIVE;
    end else begin
      nxt_phase = S_VFP;
    end
    nxt_href = (nxt_phase == S_ACTIVE) && (nxt_byte < c_bw'(c_act_bytes));
  end

  // Test-pattern pixel for the upcoming byte and its byte-lane selection.
  always_comb begin
    row     = c_rw'(nxt_line - c_lw'(c_first_act));
    col     = c_cw'(nxt_byte >> 1);
    col16   = 16'(col);
    row16   = 16'(row);
    pix_idx = 13'(row16 * 16'(c_img_cols) + col16);
    case (pat)
      2'd0:    pix = 16'hF800;
      2'd1:    pix = {col16[4:0], row16[5:0], col16[4:0]};
      2'd2:    pix = {3'b000, pix_idx};
      default: pix = (col16[3] ^ row16[3]) ? 16'hFFFF : 16'h0000;
    endcase
`ifdef OV7670_GEN_SWAP_RB_EN
    pix_out = {pix[4:0], pix[10:5], pix[15:11]};
`else
    pix_out = pix;
`endif
    if (!nxt_href) begin
      nxt_d = 8'h00;
    end else if (nxt_byte[0]) begin
      nxt_d = pix_out[7:0];
    end else begin
      nxt_d = pix_out[15:8];
    end
  end

  // Frame sequencer; outputs change only on the clk where pclk falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      pclk       <= 1'b0;
      vsync      <= 1'b0;
      href       <= 1'b0;
      d          <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      byte_cnt   <= '0;
      line_cnt   <= '0;
      pat        <= 2'd0;
    end else begin
      pclk       <= ~pclk;
      frame_done <= 1'b0;
      if (pclk) begin
        case (state)
          S_IDLE: begin
            if (en) begin
              state    <= S_VSYNC;
              pat      <= pattern;
              byte_cnt <= '0;
              line_cnt <= '0;
              busy     <= 1'b1;
              vsync    <= 1'b1;
              href     <= 1'b0;
              d        <= 8'h00;
            end
          end
          default: begin
            if (frame_end) begin
              frame_done <= 1'b1;
              byte_cnt   <= '0;
              line_cnt   <= '0;
              href       <= 1'b0;
              d          <= 8'h00;
              if (en) begin
                state <= S_VSYNC;
                pat   <= pattern;
                vsync <= 1'b1;
              end else begin
                state <= S_IDLE;
                busy  <= 1'b0;
                vsync <= 1'b0;
              end
            end else begin
              state    <= nxt_phase;
              byte_cnt <= nxt_byte;
              line_cnt <= nxt_line;
              vsync    <= (nxt_phase == S_VSYNC);
              href     <= nxt_href;
              d        <= nxt_d;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Scoreboard bench for ov7670_stream_gen: frames are modelled tick-by-tick from the frame arithmetic
// and queued at stimulus time; a monitor pops and compares one record per pclk falling edge.
`timescale 1ns/1ps
module tb_ov7670_stream_gen;

  localparam int L_TICKS  = 176;
  localparam int F_LINES  = 67;
  localparam int F_TICKS  = L_TICKS * F_LINES;
  localparam int F_CLKS   = 2 * F_TICKS;
  localparam int BOUND    = 30000;

  typedef struct packed {
    logic       first;
    logic       last;
    logic       vs;
    logic       hr;
    logic [7:0] d;
  } rec_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] pattern;
  logic       pclk;
  logic       vsync;
  logic       href;
  logic [7:0] d;
  logic       busy;
  logic       frame_done;

  rec_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   frame_pos = 0;
  int   frames_started = 0;
  int   cyc = 0;
  event tick_ev;

  ov7670_stream_gen dut (
    .clk(clk), .rst(rst), .en(en), .pattern(pattern), .pclk(pclk), .vsync(vsync),
    .href(href), .d(d), .busy(busy), .frame_done(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #990000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 50)
        $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_pix(input int pat, input int row, input int col);
    int p;
    case (pat)
      0:       p = 'hF800;
      1:       p = ((col % 32) << 11) | ((row % 64) << 5) | (col % 32);
      2:       p = (row * 80 + col) % 8192;
      default: p = (((col / 8) % 2) != ((row / 8) % 2)) ? 'hFFFF : 0;
    endcase
`ifdef OV7670_GEN_SWAP_RB_EN
    p = ((p % 32) << 11) | (p & 'h07E0) | (p >> 11);
`endif
    return 16'(p);
  endfunction

  // Whole frame from the frame arithmetic: 3 vsync lines, 2 back porch, 60 active, 2 front porch.
  task automatic push_frame(input int pat);
    rec_t r;
    int line, b;
    logic [15:0] px;
    for (int t = 0; t < F_TICKS; t++) begin
      line    = t / L_TICKS;
      b       = t % L_TICKS;
      r.first = (t == 0);
      r.last  = (t == F_TICKS - 1);
      r.vs    = (line < 3);
      r.hr    = (line >= 5) && (line < 65) && (b < 160);
      px      = model_pix(pat, line - 5, b / 2);
      r.d     = !r.hr ? 8'h00 : ((b % 2 == 0) ? px[15:8] : px[7:0]);
      q.push_back(r);
    end
  endtask

  // Monitor: one scoreboard record per byte tick, idle zeros when nothing is queued.
  initial begin
    logic prev_pclk, exp_done, is_tick, exp_busy;
    int   last_first_cyc;
    rec_t r;
    prev_pclk = 1'b0;
    exp_done = 1'b0;
    last_first_cyc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_pclk = 1'b0;
        exp_done  = 1'b0;
        frame_pos = 0;
      end else begin
        is_tick   = prev_pclk && !pclk;
        prev_pclk = pclk;
        if (is_tick) begin
          if (q.size() > 0) begin
            r = q.pop_front();
            exp_busy = 1'b1;
          end else begin
            r = '0;
            exp_busy = 1'b0;
          end
          chk("vsync", 16'(vsync), 16'(r.vs));
          chk("href", 16'(href), 16'(r.hr));
          chk("d", 16'(d), 16'(r.d));
          chk("busy", 16'(busy), 16'(exp_busy));
          chk("frame_done", 16'(frame_done), 16'(exp_done));
          if (r.first) begin
            frames_started++;
            if (exp_done) chk("vsync_spacing", 16'(cyc - last_first_cyc), 16'(F_CLKS));
            last_first_cyc = cyc;
          end
          frame_pos = (r.last || !exp_busy) ? 0 : frame_pos + 1;
          exp_done  = r.last;
          ->tick_ev;
        end else begin
          chk("frame_done_pulse", 16'(frame_done), 16'h0);
        end
      end
    end
  end

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out, got no event, expected one within %0d ticks", nm, BOUND);
  endtask

  task automatic wait_pos(input int n);
    int i;
    for (i = 0; i < BOUND && frame_pos != n; i++) @(tick_ev);
    if (frame_pos != n) timeout("wait_pos");
  endtask

  task automatic wait_frames(input int n);
    int i;
    for (i = 0; i < BOUND && frames_started < n; i++) @(tick_ev);
    if (frames_started < n) timeout("wait_frames");
  endtask

  task automatic wait_empty();
    int i;
    for (i = 0; i < BOUND && q.size() > 0; i++) @(tick_ev);
    if (q.size() > 0) timeout("wait_empty");
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) @(tick_ev);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pclk"}, 16'(pclk), 16'h0);
    chk({tag, "_vsync"}, 16'(vsync), 16'h0);
    chk({tag, "_href"}, 16'(href), 16'h0);
    chk({tag, "_d"}, 16'(d), 16'h0);
    chk({tag, "_busy"}, 16'(busy), 16'h0);
    chk({tag, "_frame_done"}, 16'(frame_done), 16'h0);
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    pattern = 2'd0;
    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset");
    @(posedge clk);
    #2 rst = 1'b0;
    wait_ticks(5);

    // Back-to-back frames: pattern 2 then 3, with mid-frame en/pattern activity ignored.
    @(tick_ev);
    pattern = 2'd2;
    en = 1'b1;
    push_frame(2);
    wait_pos($urandom_range(100, 5000));
    en = 1'b0;
    wait_ticks($urandom_range(1, 6));
    en = 1'b1;
    wait_pos($urandom_range(6000, 11000));
    pattern = 2'd3;
    push_frame(3);
    wait_frames(2);
    wait_pos($urandom_range(100, 11000));
    en = 1'b0;
    pattern = 2'($urandom_range(0, 3));
    wait_empty();
    wait_ticks(4);

    // Reset in the middle of an active line, then a fresh frame.
    @(tick_ev);
    pattern = 2'd0;
    en = 1'b1;
    push_frame(0);
    wait_frames(3);
    wait_pos(5000);
    #7 rst = 1'b1;
    #1 chk_all_zero("midrst");
    q.delete();
    pattern = 2'd1;
    push_frame(1);
    @(posedge clk);
    #2 rst = 1'b0;
    wait_frames(4);
    wait_pos($urandom_range(100, 11000));
    en = 1'b0;
    wait_empty();
    wait_ticks(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
